// File: rtl/normal_readback.sv
// Readback writer: walks per-transducer drive tables into a 16x512 BRAM write port
// using the normal-mode loader word layout. Optional macro: READBACK_SNAPSHOT_EN.
module normal_readback #(
  parameter int    TRANS_NUM    = 249,
  parameter string ENABLE_DELAY = "TRUE"
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 CAPTURE,
  input  logic [7:0]           DUTY        [TRANS_NUM],
  input  logic [7:0]           PHASE       [TRANS_NUM],
  input  logic [6:0]           DELAY       [TRANS_NUM],
  input  logic [TRANS_NUM-1:0] DUTY_OFFSET,
  input  logic                 DELAY_RST,
  output logic                 BRAM_WE,
  output logic [8:0]           BRAM_ADDR,
  output logic [15:0]          BRAM_DIN,
  output logic                 BUSY,
  output logic                 DONE
);

  localparam int         IW       = (TRANS_NUM > 1) ? $clog2(TRANS_NUM) : 1;
  localparam logic [7:0] LAST_IDX = 8'(TRANS_NUM - 1);
  localparam logic [8:0] RST_ADDR = 9'(256 + TRANS_NUM);
  localparam bit         DLY_EN   = (ENABLE_DELAY == "TRUE");

  // 256 transducers would place the DELAY_RST word at 0x200, wrapping onto address 0.
  generate
    if (TRANS_NUM < 1 || TRANS_NUM > 255) begin : g_bad_trans_num
      $fatal(1, "normal_readback: TRANS_NUM must be in 1..255");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE,
    DUTY_PHASE,
    DELAY_OFFSET,
    DELAY_RESET,
    FINISH
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic        pend_q, pend_d;
  logic        accept;

  logic        we_q, we_d;
  logic [8:0]  addr_q, addr_d;
  logic [15:0] din_q, din_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [IW-1:0] sel_idx;
  logic [7:0]    sel_duty;
  logic [7:0]    sel_phase;
  logic [6:0]    sel_delay;
  logic          sel_off;
  logic          sel_rst;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (CAPTURE) begin
          accept  = 1'b1;
          state_d = DUTY_PHASE;
          idx_d   = 8'd0;
        end
      end
      DUTY_PHASE: begin
        pend_d = pend_q | CAPTURE;
        if (idx_q == LAST_IDX) begin
          idx_d   = 8'd0;
          state_d = DELAY_OFFSET;
        end else begin
          idx_d = 8'(idx_q + 8'd1);
        end
      end
      DELAY_OFFSET: begin
        pend_d = pend_q | CAPTURE;
        if (idx_q == LAST_IDX) begin
          idx_d   = 8'd0;
          state_d = DELAY_RESET;
        end else begin
          idx_d = 8'(idx_q + 8'd1);
        end
      end
      DELAY_RESET: begin
        pend_d  = pend_q | CAPTURE;
        state_d = FINISH;
      end
      FINISH: begin
        // A request landing in this very cycle restarts just like a stored one.
        pend_d = 1'b0;
        if (pend_q || CAPTURE) begin
          accept  = 1'b1;
          state_d = DUTY_PHASE;
          idx_d   = 8'd0;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 8'd0;
        pend_d  = 1'b0;
      end
    endcase
  end

  assign sel_idx = idx_d[IW-1:0];

`ifdef READBACK_SNAPSHOT_EN
  logic [7:0]           shadow_duty_q  [TRANS_NUM];
  logic [7:0]           shadow_duty_d  [TRANS_NUM];
  logic [7:0]           shadow_phase_q [TRANS_NUM];
  logic [7:0]           shadow_phase_d [TRANS_NUM];
  logic [6:0]           shadow_delay_q [TRANS_NUM];
  logic [6:0]           shadow_delay_d [TRANS_NUM];
  logic [TRANS_NUM-1:0] shadow_off_q, shadow_off_d;
  logic                 shadow_rst_q, shadow_rst_d;

  always_comb begin
    shadow_duty_d  = shadow_duty_q;
    shadow_phase_d = shadow_phase_q;
    shadow_delay_d = shadow_delay_q;
    shadow_off_d   = shadow_off_q;
    shadow_rst_d   = shadow_rst_q;
    if (accept) begin
      shadow_duty_d  = DUTY;
      shadow_phase_d = PHASE;
      shadow_delay_d = DELAY;
      shadow_off_d   = DUTY_OFFSET;
      shadow_rst_d   = DELAY_RST;
    end
  end

  // Snapshot contents only matter once loaded by an accept, so no reset is needed.
  always_ff @(posedge CLK) begin
    shadow_duty_q  <= shadow_duty_d;
    shadow_phase_q <= shadow_phase_d;
    shadow_delay_q <= shadow_delay_d;
    shadow_off_q   <= shadow_off_d;
    shadow_rst_q   <= shadow_rst_d;
  end

  // The first word is formed in the accept cycle itself, before the copy lands.
  always_comb begin
    if (accept) begin
      sel_duty  = DUTY[sel_idx];
      sel_phase = PHASE[sel_idx];
      sel_delay = DELAY[sel_idx];
      sel_off   = DUTY_OFFSET[sel_idx];
      sel_rst   = DELAY_RST;
    end else begin
      sel_duty  = shadow_duty_q[sel_idx];
      sel_phase = shadow_phase_q[sel_idx];
      sel_delay = shadow_delay_q[sel_idx];
      sel_off   = shadow_off_q[sel_idx];
      sel_rst   = shadow_rst_q;
    end
  end
`else
  always_comb begin
    sel_duty  = DUTY[sel_idx];
    sel_phase = PHASE[sel_idx];
    sel_delay = DELAY[sel_idx];
    sel_off   = DUTY_OFFSET[sel_idx];
    sel_rst   = DELAY_RST;
  end
`endif

  // Outputs are formed from the next state so they line up with the write cycle.
  always_comb begin
    we_d   = 1'b0;
    addr_d = 9'd0;
    din_d  = 16'd0;
    case (state_d)
      DUTY_PHASE: begin
        we_d   = 1'b1;
        addr_d = {1'b0, idx_d};
        din_d  = {sel_duty, sel_phase};
      end
      DELAY_OFFSET: begin
        we_d   = 1'b1;
        addr_d = 9'h100 + {1'b0, idx_d};
        din_d  = {7'b0, sel_off, 1'b0, (DLY_EN ? sel_delay : 7'd0)};
      end
      DELAY_RESET: begin
        we_d   = 1'b1;
        addr_d = RST_ADDR;
        din_d  = {15'b0, DLY_EN & sel_rst};
      end
      default: begin
        we_d   = 1'b0;
        addr_d = 9'd0;
        din_d  = 16'd0;
      end
    endcase
    busy_d = we_d;
    done_d = (state_d == FINISH);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      idx_q   <= 8'd0;
      pend_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 9'd0;
      din_q   <= 16'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign BRAM_WE   = we_q;
  assign BRAM_ADDR = addr_q;
  assign BRAM_DIN  = din_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;

endmodule

// File: tb/tb_normal_readback.sv
// Self-checking bench for normal_readback: directed table, snapshot, pending, reset and
// randomized traffic against a cycle-indexed reference model (TRANS_NUM = 4).
module tb_normal_readback;

  localparam int N = 4;
  localparam int H = 2048;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         capture;
  logic [7:0]   duty  [N];
  logic [7:0]   phase [N];
  logic [6:0]   delay [N];
  logic [N-1:0] doff;
  logic         drst;

  logic        we_e, busy_e, done_e;
  logic [8:0]  addr_e;
  logic [15:0] din_e;
  logic        we_d, busy_d, done_d;
  logic [8:0]  addr_d;
  logic [15:0] din_d;

  normal_readback #(.TRANS_NUM(N), .ENABLE_DELAY("TRUE")) dut_en (
    .CLK(clk), .RST_N(rst_n), .CAPTURE(capture),
    .DUTY(duty), .PHASE(phase), .DELAY(delay), .DUTY_OFFSET(doff), .DELAY_RST(drst),
    .BRAM_WE(we_e), .BRAM_ADDR(addr_e), .BRAM_DIN(din_e), .BUSY(busy_e), .DONE(done_e)
  );

  normal_readback #(.TRANS_NUM(N), .ENABLE_DELAY("FALSE")) dut_dis (
    .CLK(clk), .RST_N(rst_n), .CAPTURE(capture),
    .DUTY(duty), .PHASE(phase), .DELAY(delay), .DUTY_OFFSET(doff), .DELAY_RST(drst),
    .BRAM_WE(we_d), .BRAM_ADDR(addr_d), .BRAM_DIN(din_d), .BUSY(busy_d), .DONE(done_d)
  );

  typedef struct {
    logic [8:0]  addr;
    logic [15:0] din_en;
    logic [15:0] din_dis;
  } vec_t;

  vec_t tbl [2*N+1];

  // Input history per cycle; a pass's words are derived from it by pass-relative offset.
  logic [7:0]   h_duty  [H][N];
  logic [7:0]   h_phase [H][N];
  logic [6:0]   h_delay [H][N];
  logic [N-1:0] h_doff  [H];
  logic         h_drst  [H];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pass_start = -1;
  bit pend = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic void expect_out(input bit en, output logic we, output logic [8:0] a,
                                     output logic [15:0] d, output logic dn);
    int k, s, j;
    we = 1'b0; a = 9'd0; d = 16'd0; dn = 1'b0;
    if (pass_start >= 0) begin
      k = cyc - pass_start - 1;
`ifdef READBACK_SNAPSHOT_EN
      s = pass_start;
`else
      s = cyc - 1;
`endif
      if (k >= 0 && k < N) begin
        we = 1'b1; a = 9'(k);
        d = {h_duty[s][k], h_phase[s][k]};
      end else if (k >= N && k < 2*N) begin
        j = k - N;
        we = 1'b1; a = 9'(256 + j);
        d = {7'b0, h_doff[s][j], 1'b0, (en ? h_delay[s][j] : 7'd0)};
      end else if (k == 2*N) begin
        we = 1'b1; a = 9'(256 + N);
        d = {15'b0, en & h_drst[s]};
      end else if (k == 2*N + 1) begin
        dn = 1'b1;
      end
    end
  endfunction

  task automatic check_model();
    logic we, dn;
    logic [8:0] a;
    logic [15:0] d;
    expect_out(1'b1, we, a, d, dn);
    chk("en_we", we_e, we);
    chk("en_addr", addr_e, a);
    chk("en_din", din_e, d);
    chk("en_busy", busy_e, we);
    chk("en_done", done_e, dn);
    expect_out(1'b0, we, a, d, dn);
    chk("dis_we", we_d, we);
    chk("dis_addr", addr_d, a);
    chk("dis_din", din_d, d);
    chk("dis_busy", busy_d, we);
    chk("dis_done", done_d, dn);
  endtask

  // Pass scheduling: busy for 2N+1 write cycles, done the cycle after, restart if requested.
  task automatic model_update(input bit cap);
    if (pass_start >= 0 && cyc == pass_start + 2*N + 2) begin
      if (pend || cap) pass_start = cyc;
      else pass_start = -1;
      pend = 1'b0;
    end else if (pass_start >= 0 && cyc > pass_start && cyc <= pass_start + 2*N + 1) begin
      if (cap) pend = 1'b1;
    end else if (cap) begin
      pass_start = cyc;
      pend = 1'b0;
    end
  endtask

  task automatic tick(input bit cap);
    capture = cap;
    for (int i = 0; i < N; i++) begin
      h_duty[cyc][i]  = duty[i];
      h_phase[cyc][i] = phase[i];
      h_delay[cyc][i] = delay[i];
    end
    h_doff[cyc] = doff;
    h_drst[cyc] = drst;
    if (rst_n) model_update(cap);
    @(negedge clk);
    cyc++;
    if (cyc >= H) begin
      $display("FAIL history_bound cycle=%0d actual=%0d expected<%0d", cyc, cyc, H);
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "history overflow");
    end
    check_model();
  endtask

  task automatic set_directed();
    duty[0] = 8'd10; duty[1] = 8'd20; duty[2] = 8'd30; duty[3] = 8'd40;
    phase[0] = 8'd1; phase[1] = 8'd2; phase[2] = 8'd3; phase[3] = 8'd4;
    delay[0] = 7'd5; delay[1] = 7'd6; delay[2] = 7'd7; delay[3] = 7'd127;
    doff = 4'b1001;
    drst = 1'b1;
  endtask

  task automatic set_random();
    for (int i = 0; i < N; i++) begin
      duty[i]  = 8'($urandom);
      phase[i] = 8'($urandom);
      delay[i] = 7'($urandom);
    end
    doff = N'($urandom);
    drst = 1'($urandom);
  endtask

  int wcount;

  initial begin
    tbl[0] = '{9'h000, 16'h0A01, 16'h0A01};
    tbl[1] = '{9'h001, 16'h1402, 16'h1402};
    tbl[2] = '{9'h002, 16'h1E03, 16'h1E03};
    tbl[3] = '{9'h003, 16'h2804, 16'h2804};
    tbl[4] = '{9'h100, 16'h0105, 16'h0100};
    tbl[5] = '{9'h101, 16'h0006, 16'h0000};
    tbl[6] = '{9'h102, 16'h0007, 16'h0000};
    tbl[7] = '{9'h103, 16'h017F, 16'h0100};
    tbl[8] = '{9'h104, 16'h0001, 16'h0000};

    rst_n = 1'b0;
    capture = 1'b0;
    set_directed();

    @(negedge clk);
    chk("reset_we", we_e, 1'b0);
    chk("reset_addr", addr_e, 9'd0);
    chk("reset_din", din_e, 16'd0);
    chk("reset_busy", busy_e, 1'b0);
    chk("reset_done", done_e, 1'b0);
    rst_n = 1'b1;
    tick(1'b0);
    tick(1'b0);

    // Directed pass against the table
    tick(1'b1);
    for (int r = 0; r < 2*N+1; r++) begin
      chk("tbl_we", we_e, 1'b1);
      chk("tbl_addr_en", addr_e, tbl[r].addr);
      chk("tbl_din_en", din_e, tbl[r].din_en);
      chk("tbl_addr_dis", addr_d, tbl[r].addr);
      chk("tbl_din_dis", din_d, tbl[r].din_dis);
      tick(1'b0);
    end
    chk("tbl_done_en", done_e, 1'b1);
    chk("tbl_busy_fall", busy_e, 1'b0);
    chk("tbl_done_dis", done_d, 1'b1);
    tick(1'b0);
    chk("tbl_done_pulse", done_e, 1'b0);
    tick(1'b0);

    // DUTY[3] changes two cycles after accept
    tick(1'b1);
    tick(1'b0);
    duty[3] = 8'd99;
    tick(1'b0);
    tick(1'b0);
    chk("snap_addr", addr_e, 9'h003);
`ifdef READBACK_SNAPSHOT_EN
    chk("snap_din", din_e, 16'h2804);
`else
    chk("snap_din", din_e, 16'h6304);
`endif
    for (int i = 0; i < 8; i++) tick(1'b0);
    duty[3] = 8'd40;

    // Three requests during a pass, one of them in the done cycle
    tick(1'b1);
    wcount = 0;
    for (int c = 0; c < 25; c++) begin
      if (we_e) wcount++;
      tick(c == 2 || c == 5 || c == 9);
    end
    chk("pending_writes", wcount, 18);
    chk("pending_idle", busy_e, 1'b0);
    tick(1'b0);

    // Asynchronous reset at write 3
    tick(1'b1);
    tick(1'b0);
    tick(1'b0);
    tick(1'b0);
    chk("pre_reset_addr", addr_e, 9'h003);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_we", we_e, 1'b0);
    chk("async_rst_busy", busy_e, 1'b0);
    chk("async_rst_done", done_e, 1'b0);
    chk("async_rst_addr", addr_e, 9'd0);
    chk("async_rst_din", din_e, 16'd0);
    pass_start = -1;
    pend = 1'b0;
    tick(1'b1);
    tick(1'b0);
    rst_n = 1'b1;
    wcount = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1'b0);
      if (we_e || we_d) wcount++;
    end
    chk("post_reset_quiet", wcount, 0);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) set_random();
      tick($urandom_range(0, 9) == 0);
    end
    for (int i = 0; i < 2*(2*N+3); i++) tick(1'b0);
    chk("final_idle", busy_e, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
